// File: rtl/exibe_sequencia.sv
`default_nettype none
// ============================================================================
// exibe_sequencia : plays ROM entries 0..rodada on the LEDs, each lit for
//                   TEMPO_ACESO cycles followed by TEMPO_APAGADO dark cycles.
// Revision 1.0
// ============================================================================
module exibe_sequencia #(
    parameter int TEMPO_ACESO   = 1000,
    parameter int TEMPO_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic [3:0] rodada,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado,
    output logic [3:0] db_indice
);

    localparam int TEMPO_MAX = (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
    localparam int CW        = $clog2(TEMPO_MAX) + 1;
    localparam logic [CW-1:0] FIM_ACESO   = CW'(TEMPO_ACESO - 1);
    localparam logic [CW-1:0] FIM_APAGADO = CW'(TEMPO_APAGADO - 1);

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        ENDERECA = 4'd1,
        ESPERA   = 4'd2,
        ACESO    = 4'd3,
        APAGADO  = 4'd4,
        FINAL    = 4'd5
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [3:0]    indice_q, indice_d;
    logic [3:0]    rodada_q, rodada_d;
    logic [3:0]    leds_q, leds_d;
    logic [CW-1:0] cont_q, cont_d;
    logic          pronto_q, pronto_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            indice_q <= 4'd0;
            rodada_q <= 4'd0;
            leds_q   <= 4'd0;
            cont_q   <= '0;
            pronto_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            indice_q <= indice_d;
            rodada_q <= rodada_d;
            leds_q   <= leds_d;
            cont_q   <= cont_d;
            pronto_q <= pronto_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        indice_d = indice_q;
        rodada_d = rodada_q;
        leds_d   = leds_q;
        cont_d   = cont_q;

        case (estado_q)
            OCIOSO: begin
                leds_d   = 4'd0;
                indice_d = 4'd0;
                cont_d   = '0;
                if (iniciar) begin
                    rodada_d = rodada;
                    estado_d = ENDERECA;
                end
            end
            ENDERECA: begin
                estado_d = ESPERA;
            end
            ESPERA: begin
                // ROM word for indice_q is valid now, one cycle after the address
                leds_d   = dado;
                cont_d   = '0;
                estado_d = ACESO;
            end
            ACESO: begin
                if (cont_q == FIM_ACESO) begin
                    leds_d   = 4'd0;
                    cont_d   = '0;
                    estado_d = APAGADO;
                end else begin
                    cont_d = cont_q + CW'(1);
                end
            end
            APAGADO: begin
                if (cont_q == FIM_APAGADO) begin
                    cont_d = '0;
                    // indice never exceeds rodada_q, so it cannot wrap past 15
                    if (indice_q == rodada_q) begin
                        estado_d = FINAL;
                    end else begin
                        indice_d = indice_q + 4'd1;
                        estado_d = ENDERECA;
                    end
                end else begin
                    cont_d = cont_q + CW'(1);
                end
            end
            FINAL: begin
                indice_d = 4'd0;
                estado_d = OCIOSO;
            end
            default: begin
                leds_d   = 4'd0;
                indice_d = 4'd0;
                cont_d   = '0;
                estado_d = OCIOSO;
            end
        endcase

        if (parar) begin
            leds_d   = 4'd0;
            indice_d = 4'd0;
            cont_d   = '0;
            estado_d = OCIOSO;
        end

        pronto_d = (estado_d == FINAL);
    end

    assign endereco  = indice_q;
    assign leds      = leds_q;
    assign ocupado   = (estado_q != OCIOSO);
    assign pronto    = pronto_q;
    assign db_estado = estado_q;
    assign db_indice = indice_q;

endmodule
`default_nettype wire

// File: tb/tb_exibe_sequencia.sv
`default_nettype none
// ============================================================================
// tb_exibe_sequencia : directed bench with a synchronous 16x4 ROM model.
// Revision 1.0
// ============================================================================
module tb_exibe_sequencia;

    localparam int TA = 4;
    localparam int TB = 2;
    localparam int P  = 2 + TA + TB;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       parar;
    logic [3:0] rodada;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;
    logic [3:0] db_indice;

    int passed = 0;
    int total  = 0;

    exibe_sequencia #(
        .TEMPO_ACESO   (TA),
        .TEMPO_APAGADO (TB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .parar     (parar),
        .rodada    (rodada),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado),
        .db_indice (db_indice)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] rom_word(input int a);
        case (a)
            0: return 4'b0001;  1: return 4'b0100;  2: return 4'b1000;  3: return 4'b0010;
            4: return 4'b0011;  5: return 4'b0101;  6: return 4'b0110;  7: return 4'b0111;
            8: return 4'b1001;  9: return 4'b1010; 10: return 4'b1011; 11: return 4'b1100;
            12: return 4'b1101; 13: return 4'b1110; 14: return 4'b1111; default: return 4'b1111;
        endcase
    endfunction

    always @(posedge clock) dado <= rom_word(int'(endereco));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts a run at edge 0 and checks every cycle against the documented
    // timing. poke>0 pulses iniciar (with a bogus rodada) in that cycle;
    // abort>0 asserts parar in that cycle and ends the run there.
    task automatic run_seq(input int r, input int poke, input int abort);
        int n, k, off;
        logic [3:0] e_leds, e_est, e_end;
        n = (r + 1) * P;
        rodada  = 4'(r);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        for (int c = 1; c <= n + 2; c++) begin
            k   = (c - 1) / P;
            off = (c - 1) % P + 1;
            if (c <= n) begin
                e_leds = (off >= 3 && off <= 2 + TA) ? rom_word(k) : 4'd0;
                e_est  = (off == 1) ? 4'd1 : (off == 2) ? 4'd2 : (off <= 2 + TA) ? 4'd3 : 4'd4;
                e_end  = 4'(k);
            end else begin
                e_leds = 4'd0;
                e_est  = (c == n + 1) ? 4'd5 : 4'd0;
                e_end  = (c == n + 1) ? 4'(r) : 4'd0;
            end
            check($sformatf("r%0d c%0d leds", r, c), 32'(leds), 32'(e_leds));
            check($sformatf("r%0d c%0d estado", r, c), 32'(db_estado), 32'(e_est));
            check($sformatf("r%0d c%0d endereco", r, c), 32'(endereco), 32'(e_end));
            check($sformatf("r%0d c%0d db_indice", r, c), 32'(db_indice), 32'(e_end));
            check($sformatf("r%0d c%0d pronto", r, c), 32'(pronto), 32'(c == n + 1));
            check($sformatf("r%0d c%0d ocupado", r, c), 32'(ocupado), 32'(c <= n + 1));
            if (c == abort) begin
                parar = 1'b1;
                tick();
                parar = 1'b0;
                check("abort leds", 32'(leds), 32'd0);
                check("abort estado", 32'(db_estado), 32'd0);
                check("abort ocupado", 32'(ocupado), 32'd0);
                check("abort endereco", 32'(endereco), 32'd0);
                for (int j = 0; j < 30; j++) begin
                    check($sformatf("abort pronto %0d", j), 32'(pronto), 32'd0);
                    check($sformatf("abort idle %0d", j), 32'(db_estado), 32'd0);
                    tick();
                end
                return;
            end
            if (c == poke) begin
                iniciar = 1'b1;
                rodada  = 4'd0;
            end else begin
                iniciar = 1'b0;
            end
            tick();
        end
        iniciar = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        iniciar = 1'b0;
        parar   = 1'b0;
        rodada  = 4'd0;
        #12;
        check("rst leds", 32'(leds), 32'd0);
        check("rst endereco", 32'(endereco), 32'd0);
        check("rst ocupado", 32'(ocupado), 32'd0);
        check("rst pronto", 32'(pronto), 32'd0);
        check("rst estado", 32'(db_estado), 32'd0);
        check("rst indice", 32'(db_indice), 32'd0);
        @(negedge clock) reset = 1'b1;
        tick();
        tick();
        check("idle estado", 32'(db_estado), 32'd0);

        // single entry, then three entries
        run_seq(0, 0, 0);
        run_seq(2, 0, 0);

        // abort during the second ACESO, then fresh restart
        run_seq(2, 0, 12);
        run_seq(0, 0, 0);

        // iniciar pulses during ACESO are ignored
        run_seq(2, 4, 0);
        run_seq(1, 13, 0);

        // iniciar and parar together in OCIOSO
        iniciar = 1'b1;
        parar   = 1'b1;
        rodada  = 4'd3;
        tick();
        check("prio estado", 32'(db_estado), 32'd0);
        check("prio ocupado", 32'(ocupado), 32'd0);
        tick();
        iniciar = 1'b0;
        parar   = 1'b0;
        check("prio estado2", 32'(db_estado), 32'd0);
        tick();

        // full 16-entry sequence
        run_seq(15, 0, 0);

        // asynchronous reset mid-ESPERA of entry 1
        rodada  = 4'd2;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        repeat (9) tick();
        check("pre-rst estado", 32'(db_estado), 32'd2);
        check("pre-rst endereco", 32'(endereco), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst leds", 32'(leds), 32'd0);
        check("arst endereco", 32'(endereco), 32'd0);
        check("arst ocupado", 32'(ocupado), 32'd0);
        check("arst pronto", 32'(pronto), 32'd0);
        check("arst estado", 32'(db_estado), 32'd0);
        check("arst indice", 32'(db_indice), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            check($sformatf("post-rst idle %0d", j), 32'(db_estado), 32'd0);
            check($sformatf("post-rst ocupado %0d", j), 32'(ocupado), 32'd0);
        end
        run_seq(1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exibe_sequencia.md
# exibe_sequencia

Sequence presenter for the memory game: on request it reads the stored sequence from the synchronous 16x4 ROM, positions 0 through the current round, and shows each entry on the LEDs for a fixed on-time followed by a fixed dark gap. It is the output half of the play loop: it plays the sequence to the player, and the existing datapath then receives and compares the player's button presses against the same ROM. It sits beside the datapath, shares the ROM address/data pair through a mux owned by the control unit, and reports completion to that control unit.

## Interface
- TEMPO_ACESO, 1000: cycles each entry is lit; must be at least 1.
- TEMPO_APAGADO, 500: dark cycles after each entry; must be at least 1.
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- iniciar  input  1  start request, sampled only in OCIOSO.
- parar  input  1  synchronous abort, valid in any state.
- rodada  input  4  index of the last entry to show; sampled when the start is accepted.
- dado  input  4  ROM data_out, valid one cycle after the address is presented.
- endereco  output  4  ROM address, equal to the internal index register.
- leds  output  4  LED drive, registered.
- ocupado  output  1  high in every state except OCIOSO.
- pronto  output  1  one-cycle pulse when a presentation completes normally.
- db_estado  output  4  state encoding, for debug.
- db_indice  output  4  current index, for debug.

## Operation
- States and db_estado encoding:
  - OCIOSO=0
  - ENDERECA=1
  - ESPERA=2
  - ACESO=3
  - APAGADO=4
  - FINAL=5
  - Unused codes return to OCIOSO.
- OCIOSO:
  - Outputs: leds=0, indice=0, ocupado=0.
  - iniciar=1 and parar=0 latches rodada into rodada_reg, clears indice and goes to ENDERECA.
- ENDERECA: lasts 1 cycle, with endereco=indice. Goes to ESPERA.
- ESPERA: lasts 1 cycle while the ROM output settles. At the end of the cycle the leds register loads dado and the time counter clears. Goes to ACESO.
- ACESO:
  - leds holds the loaded value for TEMPO_ACESO cycles.
  - On the last cycle, leds is cleared, the counter clears and the block goes to APAGADO.
- APAGADO: leds=0 for TEMPO_APAGADO cycles. On the last cycle:
  - if indice==rodada_reg, go to FINAL;
  - otherwise indice increments and the block goes to ENDERECA.
- FINAL: pronto=1 for one cycle, then OCIOSO.
- parar=1 in any state:
  - Next state is OCIOSO, with leds=0 and indice=0.
  - pronto is not asserted.
  - parar has priority over iniciar.
- iniciar while ocupado=1 is ignored. A change to rodada mid-presentation has no effect.
- Index arithmetic:
  - The index is 4 bits.
  - rodada=15 shows all 16 entries. The index stops at 15 and never wraps to 0 during a presentation.
- Time counter:
  - Width is ceil(log2(max(TEMPO_ACESO, TEMPO_APAGADO)))+1 bits.
  - It counts from 0 to T-1.
- Reset (asynchronous, active-low):
  - Returns to OCIOSO immediately.
  - Reset values: leds=0, endereco=0, ocupado=0, pronto=0, db_estado=0, db_indice=0; rodada_reg and the counter are also 0.
  - This holds even mid-presentation.

## Timing
- Let N = rodada+1 and P = 2+TEMPO_ACESO+TEMPO_APAGADO.
- With iniciar accepted at edge 0, entry k (0-based) occupies cycles k*P+1 through (k+1)*P:
  - ENDERECA in cycle k*P+1;
  - ESPERA in cycle k*P+2;
  - leds nonzero (if the ROM word is nonzero) in cycles k*P+3 through k*P+2+TEMPO_ACESO.
- pronto is high in cycle N*P+1. ocupado drops in cycle N*P+2.
- ocupado rises in cycle 1 and stays high through FINAL.
- A new iniciar is accepted no earlier than the edge ending cycle N*P+2.
- parar sampled at edge j: OCIOSO with leds=0 from cycle j+1.

## Test plan
- Single entry:
  - Setup: TEMPO_ACESO=4, TEMPO_APAGADO=2, ROM[0]=4'b0001, rodada=0, iniciar pulse at edge 0.
  - Required: leds=0001 in cycles 3-6, 0 in cycles 7-8; pronto exactly in cycle 9; ocupado high in cycles 1-9.
- Three entries:
  - Setup: ROM[0..2]=0001, 0100, 1000, rodada=2, same timing.
  - Required: endereco steps 0, 1, 2 at cycles 1, 9, 17; leds show 0001, 0100, 1000 in turn; pronto in cycle 25.
- Abort:
  - Stimulus: parar asserted during the second ACESO of a rodada=2 run.
  - Required: next cycle leds=0, db_estado=0, ocupado=0; pronto never asserted. A fresh iniciar restarts from endereco=0.
- Busy/priority:
  - Stimulus: iniciar pulses during ACESO.
  - Required: no effect on the sequence and no restart.
  - Stimulus: iniciar and parar together in OCIOSO.
  - Required: stays in OCIOSO.
- Full sequence:
  - Stimulus: rodada=15.
  - Required: 16 entries, last endereco=15 with no wrap to 0; pronto in cycle 16*P+1=129.
- Asynchronous reset:
  - Stimulus: reset=0 mid-ESPERA, between clock edges.
  - Required: all outputs 0 immediately. After release, the block idles until iniciar.
